// File: rtl/program_loader.sv
// program_loader: packs a byte stream into 32-bit instruction words (big-endian)
// and writes them to instruction memory starting at word 0. Loading ends after a
// HALT_WORD is written or after DEPTH words (overflow).
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (mod-256 sum of accepted bytes).
// All outputs are registered; memory samples the write bus on the following negedge.
module program_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      nextState_s;
    logic [1:0]  byteCnt_r;
    logic [23:0] asmWord_r;
    logic        accept_s;
    logic        lastAddr_s;
    logic        isHalt_s;
    logic        inReadyNxt_s;
    logic        memWrNxt_s;
    logic        busyNxt_s;
    logic        doneNxt_s;

    // in_ready is high exactly while in RECV, so this is the byte handshake
    assign accept_s   = in_ready & in_valid;
    assign lastAddr_s = (mem_addr == 32'(DEPTH - 1));
    assign isHalt_s   = (mem_data == HALT_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE and DONE
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    nextState_s = RECV;
                end else begin
                    nextState_s = IDLE;
                end
            end
            RECV: begin
                if (accept_s && (byteCnt_r == 2'd3)) begin
                    nextState_s = WRITE;
                end else begin
                    nextState_s = RECV;
                end
            end
            WRITE: begin
                if (isHalt_s || lastAddr_s) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = RECV;
                end
            end
            DONE: begin
                if (start) begin
                    nextState_s = RECV;
                end else begin
                    nextState_s = DONE;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered flags line up with it
    always_comb begin
        inReadyNxt_s = 1'b0;
        memWrNxt_s   = 1'b0;
        busyNxt_s    = 1'b0;
        doneNxt_s    = 1'b0;
        case (nextState_s)
            IDLE: begin
                busyNxt_s = 1'b0;
            end
            RECV: begin
                inReadyNxt_s = 1'b1;
                busyNxt_s    = 1'b1;
            end
            WRITE: begin
                memWrNxt_s = 1'b1;
                busyNxt_s  = 1'b1;
            end
            DONE: begin
                doneNxt_s = 1'b1;
            end
            default: begin
                busyNxt_s = 1'b0;
            end
        endcase
    end

    // Registered status and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= inReadyNxt_s;
            mem_wr   <= memWrNxt_s;
            busy     <= busyNxt_s;
            done     <= doneNxt_s;
        end
    end

    // Word assembly, write address and overflow tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            byteCnt_r <= 2'd0;
            asmWord_r <= 24'd0;
            mem_addr  <= 32'd0;
            mem_data  <= 32'd0;
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        byteCnt_r <= 2'd0;
                        asmWord_r <= 24'd0;
                        mem_addr  <= 32'd0;
                        overflow  <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        if (byteCnt_r == 2'd3) begin
                            mem_data  <= {asmWord_r, in_byte};
                            asmWord_r <= 24'd0;
                            byteCnt_r <= 2'd0;
                        end else begin
                            asmWord_r <= {asmWord_r[15:0], in_byte};
                            byteCnt_r <= byteCnt_r + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (!isHalt_s) begin
                        if (lastAddr_s) begin
                            overflow <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + 32'd1;
                        end
                    end
                end
                default: begin
                    byteCnt_r <= byteCnt_r;
                end
            endcase
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running mod-256 sum of accepted bytes; cleared when a new load starts
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= 8'h00;
        end else if (((state_r == IDLE) || (state_r == DONE)) && start) begin
            checksum <= 8'h00;
        end else if (accept_s) begin
            checksum <= checksum + in_byte;
        end else begin
            checksum <= checksum;
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule
